// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered sync, DE, colour and start pulses (optional VGA_TEST_PATTERN_EN colour bars)
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   COLOR_W  = 4,
    parameter int   COORD_W  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_pix_ce,
    input  logic [3*COLOR_W-1:0]   i_csel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   i_pattern_sel,
`endif
    output logic [COORD_W-1:0]     o_hcoord,
    output logic [COORD_W-1:0]     o_vcoord,
    output logic [COLOR_W-1:0]     o_red,
    output logic [COLOR_W-1:0]     o_green,
    output logic [COLOR_W-1:0]     o_blue,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic                   o_line_start,
    output logic                   o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // Region bounds carry one extra bit so a sync pulse ending exactly at 2^COORD_W still compares correctly.
    localparam logic [COORD_W:0] H_ACT  = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] HS_BEG = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0] HS_END = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0] V_ACT  = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0] VS_BEG = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0] VS_END = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_hcount;
    logic [COORD_W-1:0] r_vcount;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic               r_line_start;
    logic               r_frame_start;

    logic [COORD_W:0]   w_h_ext;
    logic [COORD_W:0]   w_v_ext;
    logic               w_de;
    logic               w_hs_on;
    logic               w_vs_on;
    logic               w_line_start;
    logic               w_frame_start;
    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    assign w_h_ext       = {1'b0, r_hcount};
    assign w_v_ext       = {1'b0, r_vcount};
    assign w_de          = (w_h_ext < H_ACT) && (w_v_ext < V_ACT);
    assign w_hs_on       = (w_h_ext >= HS_BEG) && (w_h_ext < HS_END);
    assign w_vs_on       = (w_v_ext >= VS_BEG) && (w_v_ext < VS_END);
    assign w_line_start  = (r_hcount == '0);
    assign w_frame_start = w_line_start && (r_vcount == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [COORD_W-1:0] BAR_WIDTH = COORD_W'(H_ACTIVE / 8);
    logic [2:0] w_bar;
    assign w_bar = 3'(r_hcount / BAR_WIDTH);
`endif

    // Pixel colour source: user colour, or colour bars when the test pattern is selected.
    always_comb begin
        w_red   = i_csel[3*COLOR_W-1:2*COLOR_W];
        w_green = i_csel[2*COLOR_W-1:COLOR_W];
        w_blue  = i_csel[COLOR_W-1:0];
`ifdef VGA_TEST_PATTERN_EN
        if (i_pattern_sel) begin
            w_red   = {COLOR_W{w_bar[2]}};
            w_green = {COLOR_W{w_bar[1]}};
            w_blue  = {COLOR_W{w_bar[0]}};
        end
`endif
    end

    // Raster counters: horizontal wraps at line end and carries into the vertical counter.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (i_pix_ce) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                if (r_vcount == V_LAST) begin
                    r_vcount <= '0;
                end else begin
                    r_vcount <= r_vcount + COORD_W'(1);
                end
            end else begin
                r_hcount <= r_hcount + COORD_W'(1);
            end
        end
    end

    // Output stage: capture everything for the current counter position, one tick behind the counters.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_pix_ce) begin
            r_red         <= w_de ? w_red   : '0;
            r_green       <= w_de ? w_green : '0;
            r_blue        <= w_de ? w_blue  : '0;
            r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign o_hcoord      = r_hcount;
    assign o_vcoord      = r_vcount;
    assign o_red         = r_red;
    assign o_green       = r_green;
    assign o_blue        = r_blue;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch in lines.
REQ-005 Parameters HS_POL / VS_POL, default 0 / 0, the asserted level of each sync output.
REQ-006 Parameter COLOR_W, default 4, bits per colour channel.
REQ-007 Parameter COORD_W, default 10, coordinate width; H_TOTAL (= H_ACTIVE+H_FP+H_SYNC+H_BP) and V_TOTAL SHALL each be at most 2^COORD_W.
REQ-008 CLK  in  1  system clock, rising edge; the only clock.
REQ-009 ARST  in  1  asynchronous reset, active-high.
REQ-010 PIX_CE  in  1  pixel clock enable; all state advances only on CLK edges where PIX_CE=1 (a "tick").
REQ-011 CSEL  in  3*COLOR_W  pixel colour {R,G,B}, driven by the user from HCOORD/VCOORD.
REQ-012 HCOORD, VCOORD  out  COORD_W  registered pixel counters.
REQ-013 RED, GREEN, BLUE  out  COLOR_W each  registered colour outputs.
REQ-014 HSYNC, VSYNC  out  1  registered sync outputs.
REQ-015 DE  out  1  registered display enable, high when the output pixel is visible.
REQ-016 LINE_START, FRAME_START  out  1  registered pulses marking output pixel (0,v) and pixel (0,0).

Function
REQ-017 HCOORD SHALL count 0..H_TOTAL-1 on each tick and wrap to 0.
REQ-018 On each HCOORD wrap, VCOORD SHALL increment; at H_TOTAL-1 with V_TOTAL-1, both counters SHALL go to 0 on the same tick.
REQ-019 On each tick, the output registers SHALL capture values for the current (HCOORD,VCOORD) while the counters advance, giving an output latency of exactly one tick.
- HSYNC, VSYNC, DE, RGB and the pulses SHALL stay mutually aligned.
REQ-020 DE SHALL be 1 iff HCOORD < H_ACTIVE and VCOORD < V_ACTIVE.
- When DE=1, RGB SHALL equal CSEL[3C-1:2C], CSEL[2C-1:C] and CSEL[C-1:0], where C = COLOR_W.
- When DE=0, RGB SHALL be 0.
REQ-021 HSYNC SHALL equal HS_POL iff H_ACTIVE+H_FP <= HCOORD < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL equal ~HS_POL.
REQ-022 VSYNC SHALL equal VS_POL iff V_ACTIVE+V_FP <= VCOORD < V_ACTIVE+V_FP+V_SYNC, for the whole line; otherwise it SHALL equal ~VS_POL.
REQ-023 LINE_START SHALL be 1 iff the captured HCOORD is 0; FRAME_START SHALL be 1 iff the captured HCOORD and VCOORD are both 0.
REQ-024 Between ticks, every output and counter SHALL hold its value; a pulse therefore lasts one tick period.
REQ-025 PIX_CE held at 1 SHALL advance the timing every CLK cycle, with no gaps or stalls.

Reset
REQ-026 While ARST=1, without waiting for a clock edge, the block SHALL force:
- HCOORD=0, VCOORD=0;
- RED=GREEN=BLUE=0, DE=0, LINE_START=0, FRAME_START=0;
- HSYNC=~HS_POL, VSYNC=~VS_POL.
REQ-027 After ARST deasserts mid-frame, the first tick SHALL output pixel (0,0) with FRAME_START=1; no partial line SHALL be emitted.

Configuration
REQ-028 With macro VGA_TEST_PATTERN_EN defined, the block SHALL add input PATTERN_SEL (1 bit).
- When PATTERN_SEL=1 and DE=1, RGB SHALL show 8 vertical bars, each H_ACTIVE/8 wide.
- Bar index b = HCOORD/(H_ACTIVE/8); RED = all b[2], GREEN = all b[1], BLUE = all b[0]; CSEL is ignored.
- When PATTERN_SEL=0, or DE=0, REQ-020 SHALL apply unchanged.
REQ-029 Without VGA_TEST_PATTERN_EN, the PATTERN_SEL port and the pattern logic SHALL be absent, and RGB SHALL follow REQ-020 only.

Verification
REQ-030 Defaults, PIX_CE=1, release reset -> HCOORD 0..799 wraps, VCOORD 0..524 wraps, and FRAME_START is high every 420000 cycles.
REQ-031 Defaults -> HSYNC is low for exactly 96 consecutive ticks per line, starting one tick after HCOORD=656; VSYNC is low for exactly 1600 ticks per frame.
REQ-032 CSEL=12'hF0A constant -> RGB=F,0,A on exactly 640 ticks per line for 480 lines; RGB=0 whenever DE=0.
REQ-033 PIX_CE=1 on every 4th CLK -> counters advance only on those edges, outputs are stable between them, and a frame lasts 1680000 CLK cycles.
REQ-034 ARST pulse between edges at HCOORD=300, VCOORD=100 -> all outputs take their reset values immediately; the next tick outputs (0,0) with FRAME_START=1.
REQ-035 VGA_TEST_PATTERN_EN defined, PATTERN_SEL=1 -> output pixels h=0..79 give RGB=0,0,0; h=80..159 give 0,0,F; h=560..639 give F,F,F.
